// File: rtl/display_scan_ctrl_pkg.sv
// Shared constants for the 4-digit scan controller: blanking codes,
// the active-low hex font and a small anode-select helper.
package display_scan_ctrl_pkg;

   localparam logic [3:0] ANODE_OFF = 4'b1111;
   localparam logic [6:0] SEG_OFF   = 7'b1111111;

   // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
   localparam logic [6:0] HEX7_0 = 7'b1000000;
   localparam logic [6:0] HEX7_1 = 7'b1111001;
   localparam logic [6:0] HEX7_2 = 7'b0100100;
   localparam logic [6:0] HEX7_3 = 7'b0110000;
   localparam logic [6:0] HEX7_4 = 7'b0011001;
   localparam logic [6:0] HEX7_5 = 7'b0010010;
   localparam logic [6:0] HEX7_6 = 7'b0000010;
   localparam logic [6:0] HEX7_7 = 7'b1111000;
   localparam logic [6:0] HEX7_8 = 7'b0000000;
   localparam logic [6:0] HEX7_9 = 7'b0010000;
   localparam logic [6:0] HEX7_A = 7'b0001000;
   localparam logic [6:0] HEX7_B = 7'b0000011;
   localparam logic [6:0] HEX7_C = 7'b1000110;
   localparam logic [6:0] HEX7_D = 7'b0100001;
   localparam logic [6:0] HEX7_E = 7'b0000110;
   localparam logic [6:0] HEX7_F = 7'b0001110;

   // Active-low one-hot anode pattern for digit slot idx.
   function automatic logic [3:0] anode_on(input logic [1:0] idx);
      logic [3:0] onehot;
      onehot = 4'b0001 << idx;
      return ~onehot;
   endfunction

endpackage

// File: rtl/display_scan_ctrl_hex_to_7seg.sv
// Combinational nibble to active-low 7-segment decoder.
module hex_to_7seg
   import display_scan_ctrl_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   // Pure lookup into the hex font.
   always_comb begin
      seg = SEG_OFF;
      case (nibble)
         4'h0: seg = HEX7_0;
         4'h1: seg = HEX7_1;
         4'h2: seg = HEX7_2;
         4'h3: seg = HEX7_3;
         4'h4: seg = HEX7_4;
         4'h5: seg = HEX7_5;
         4'h6: seg = HEX7_6;
         4'h7: seg = HEX7_7;
         4'h8: seg = HEX7_8;
         4'h9: seg = HEX7_9;
         4'hA: seg = HEX7_A;
         4'hB: seg = HEX7_B;
         4'hC: seg = HEX7_C;
         4'hD: seg = HEX7_D;
         4'hE: seg = HEX7_E;
         4'hF: seg = HEX7_F;
         default: seg = SEG_OFF;
      endcase
   end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit common-anode display.
// A value loaded through the valid/ready port lands in a shadow register
// and is copied to the displayed register only at a frame boundary, so a
// frame never mixes digits from two different values.
module display_scan_ctrl
   import display_scan_ctrl_pkg::*;
#(
   parameter int SLOT_CYCLES  = 4,
   parameter int BLANK_CYCLES = 1
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        load_valid,
   input  logic [15:0] load_data,
   output logic        load_ready,
   input  logic [3:0]  digit_en,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        frame_done
);

   localparam int CW = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;
   localparam logic [CW-1:0] CYC_LAST  = CW'(SLOT_CYCLES - 1);
   localparam logic [CW-1:0] CYC_BLANK = CW'(BLANK_CYCLES);

   logic [CW-1:0] cyc;
   logic [1:0]    idx;
   logic [15:0]   shadow;
   logic [15:0]   disp;
   logic          pending;

   logic          slot_end;
   logic          frame_edge;
   logic          accept;
   logic          lit;
   logic [3:0]    nibble;
   logic [6:0]    seg_code;

   // Handshake: a load transfers on any clock where load_valid and load_ready
   // are both high. load_ready is low while a shadow value waits for its frame
   // edge (and during reset); the producer must hold load_valid/load_data
   // steady until the transfer happens.
   assign load_ready = ~pending & ~reset;
   assign accept     = load_valid & load_ready;

   assign slot_end   = (cyc == CYC_LAST);
   assign frame_edge = slot_end && (idx == 2'd3);
   assign lit        = (cyc >= CYC_BLANK) && digit_en[idx];

   // Select the displayed nibble for the current slot.
   always_comb begin
      nibble = disp[3:0];
      case (idx)
         2'd0: nibble = disp[3:0];
         2'd1: nibble = disp[7:4];
         2'd2: nibble = disp[11:8];
         2'd3: nibble = disp[15:12];
         default: nibble = disp[3:0];
      endcase
   end

   hex_to_7seg u_hex (
      .nibble (nibble),
      .seg    (seg_code)
   );

   // Slot cycle counter and digit index, digit 0 first.
   always_ff @(posedge clk) begin
      if (reset) begin
         cyc <= '0;
         idx <= 2'd0;
      end else if (slot_end) begin
         cyc <= '0;
         idx <= idx + 2'd1;
      end else begin
         cyc <= cyc + 1'b1;
      end
   end

   // Double buffer: swap at the frame edge, otherwise capture accepted loads.
   // A load accepted on the frame edge itself only fills the shadow, because
   // pending was low there and no swap is due.
   always_ff @(posedge clk) begin
      if (reset) begin
         shadow  <= 16'h0000;
         disp    <= 16'h0000;
         pending <= 1'b0;
      end else if (frame_edge && pending) begin
         disp    <= shadow;
         pending <= 1'b0;
      end else if (accept) begin
         shadow  <= load_data;
         pending <= 1'b1;
      end
   end

   // Registered display outputs; blank during the leading dead-time cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         an         <= ANODE_OFF;
         seg        <= SEG_OFF;
         frame_done <= 1'b0;
      end else begin
         frame_done <= frame_edge;
         if (lit) begin
            an  <= anode_on(idx);
            seg <= seg_code;
         end else begin
            an  <= ANODE_OFF;
            seg <= SEG_OFF;
         end
      end
   end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: a frame-position reference model pushes the
// expected {frame_done, an, seg} each clock; the monitor pops and compares.
// Directed blocks cover reset release, loads, hold/back-pressure, frame-edge
// loads, digit enables and reset with a pending value.
module tb_display_scan_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        load_valid = 1'b0;
   logic [15:0] load_data = 16'h0000;
   logic        load_ready;
   logic [3:0]  digit_en = 4'hF;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        frame_done;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference font, active-low {g,f,e,d,c,b,a}.
   logic [6:0] font [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   // Model state: frame position of the upcoming edge, buffers.
   int          mpos = 0;
   logic [15:0] disp_m = 16'h0000;
   logic [15:0] shadow_m = 16'h0000;
   logic        pend_m = 1'b0;
   logic [11:0] exp_q[$];

   always #5 clk = ~clk;

   display_scan_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_ready (load_ready),
      .digit_en   (digit_en),
      .an         (an),
      .seg        (seg),
      .frame_done (frame_done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model evaluated on each rising edge.
   always @(posedge clk) begin : model
      logic [3:0] e_an;
      logic [6:0] e_seg;
      logic       e_fd;
      int         slot;
      int         c;
      if (reset) begin
         exp_q.push_back({1'b0, 4'b1111, 7'b1111111});
         disp_m   <= 16'h0000;
         shadow_m <= 16'h0000;
         pend_m   <= 1'b0;
         mpos     <= 0;
      end else begin
         slot = mpos / 4;
         c    = mpos % 4;
         if (c >= 1 && digit_en[slot]) begin
            e_an  = ~(4'b0001 << slot);
            e_seg = font[disp_m[slot*4 +: 4]];
         end else begin
            e_an  = 4'b1111;
            e_seg = 7'b1111111;
         end
         e_fd = (mpos == 15);
         exp_q.push_back({e_fd, e_an, e_seg});
         if (mpos == 15 && pend_m) begin
            disp_m <= shadow_m;
            pend_m <= 1'b0;
         end else if (load_valid && !pend_m) begin
            shadow_m <= load_data;
            pend_m   <= 1'b1;
         end
         mpos <= (mpos + 1) % 16;
      end
   end

   // Scoreboard compare on the falling edge.
   always @(negedge clk) begin : monitor
      logic [11:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("an", an, e[10:7]);
         check("seg", seg, e[6:0]);
         check("frame_done", frame_done, e[11]);
      end
      check("load_ready", load_ready, !pend_m && !reset);
   end

   // Advance to just after the n-th following falling edge.
   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   // Present a value and hold it until it is accepted.
   task automatic send(input logic [15:0] d);
      int budget;
      bit done;
      done       = 1'b0;
      budget     = 0;
      load_valid = 1'b1;
      load_data  = d;
      while (!done && budget < 200) begin
         done = load_ready;
         tick(1);
         budget++;
      end
      load_valid = 1'b0;
      check("send_accept", done, 1);
   endtask

   initial begin : stim
      logic [3:0] an_tab [16];
      int b;
      an_tab = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
                 4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7};

      // Reset and release; E0 is the next rising edge.
      tick(3);
      check("rst_an", an, 4'hF);
      check("rst_seg", seg, 7'h7F);
      check("rst_ready", load_ready, 0);
      reset = 1'b0;
      for (int k = 0; k < 16; k++) begin
         tick(1);
         check("rel_an", an, an_tab[k]);
         check("rel_fd", frame_done, (k == 15));
      end

      // Load 1234 a couple of cycles into the frame.
      tick(2);
      send(16'h1234);
      check("ready_after_accept", load_ready, 0);
      tick(40);
      for (int k = 0; k < 16; k++) begin
         tick(1);
         if (an == 4'hE) check("d0_is_4", seg, 7'b0011001);
         if (an == 4'h7) check("d3_is_1", seg, 7'b1111001);
      end
      check("ready_again", load_ready, 1);

      // Back-to-back values: the second waits for the first to swap.
      send(16'hAAAA);
      send(16'hBBBB);
      tick(48);

      // Load landing exactly on a frame edge.
      b = 0;
      while (mpos != 15 && b < 100) begin
         tick(1);
         b++;
      end
      check("edge_align", mpos, 15);
      send(16'hC0DE);
      for (int k = 0; k < 16; k++) begin
         tick(1);
         if (an == 4'hE) check("edge_hold_d0", seg, 7'b0000011);
      end
      for (int k = 0; k < 16; k++) begin
         tick(1);
         if (an == 4'hE) check("edge_new_d0", seg, 7'b0000110);
         if (an == 4'h7) check("edge_new_d3", seg, 7'b1000110);
      end

      // Digits 1 and 3 disabled.
      digit_en = 4'b0101;
      for (int k = 0; k < 32; k++) begin
         tick(1);
         check("en_dark", (an == 4'hD) || (an == 4'h7), 0);
      end
      digit_en = 4'hF;

      // Reset mid-slot while a value is pending.
      tick(2);
      send(16'h5678);
      tick(1);
      reset = 1'b1;
      tick(1);
      check("midrst_an", an, 4'hF);
      check("midrst_seg", seg, 7'h7F);
      check("midrst_ready", load_ready, 0);
      tick(1);
      reset = 1'b0;
      tick(40);
      for (int k = 0; k < 16; k++) begin
         tick(1);
         if (an != 4'hF) check("after_rst_zero", seg, 7'b1000000);
      end

      // Random loads with a jittering digit enable.
      for (int i = 0; i < 4; i++) begin
         send(16'($urandom_range(0, 65535)));
         for (int k = 0; k < 20; k++) begin
            digit_en = 4'($urandom_range(0, 15));
            tick(1);
         end
      end
      digit_en = 4'hF;
      tick(40);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
